// File: rtl/fifo_if.sv
// rtl/fifo_if.sv - producer/consumer handshake bundle for the fifo
interface fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_write;
  logic                  write;
  logic                  full;
  logic                  almost_full;
  logic [DATA_WIDTH-1:0] data_read;
  logic                  next_read;
  logic                  empty;

  modport master (
    output data_write, write, next_read,
    input  full, almost_full, data_read, empty
  );

  modport slave (
    input  data_write, write, next_read,
    output full, almost_full, data_read, empty
  );
endinterface

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock first-word-fall-through fifo with full/almost_full/empty status
module fifo #(
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2,
  parameter int DATA_WIDTH    = 32
) (
  input logic   clk,
  input logic   rst,
  fifo_if.slave bus
);
  localparam logic [LOG_NUM_SLOTS:0]   SLOTS_C  = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
  localparam logic [LOG_NUM_SLOTS:0]   ALMOST_C = (LOG_NUM_SLOTS+1)'(NUM_SLOTS - 1);
  localparam logic [LOG_NUM_SLOTS-1:0] LAST_PTR = LOG_NUM_SLOTS'(NUM_SLOTS - 1);

  logic [DATA_WIDTH-1:0]    storage [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] wr_ptr;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr;
  logic [LOG_NUM_SLOTS:0]   count;
  logic                     full_i;
  logic                     empty_i;
  logic                     wr_acc;
  logic                     rd_acc;

  // Explicit wrap so depths that are not a power of two still cycle correctly.
  function automatic logic [LOG_NUM_SLOTS-1:0] ptr_inc(input logic [LOG_NUM_SLOTS-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty_i = (count == '0);
  assign full_i  = (count == SLOTS_C);
  assign wr_acc  = bus.write & ~full_i;
  assign rd_acc  = bus.next_read & ~empty_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        storage[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        storage[wr_ptr] <= bus.data_write;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.data_read   = storage[rd_ptr];
  assign bus.empty       = empty_i;
  assign bus.full        = full_i;
  assign bus.almost_full = (count == ALMOST_C);
endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - self-checking bench for fifo at depths 2 and 3 against a queue model
module tb_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2;
  logic rst3;

  fifo_if #(.DATA_WIDTH(32)) bus2 ();
  fifo_if #(.DATA_WIDTH(32)) bus3 ();

  fifo #(.NUM_SLOTS(2), .LOG_NUM_SLOTS(1), .DATA_WIDTH(32)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  fifo #(.NUM_SLOTS(3), .LOG_NUM_SLOTS(2), .DATA_WIDTH(32)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          sel    = 0;
  int          mcap   = 2;
  logic [31:0] mq [$];

  // {empty, full, almost_full} and head word of the instance under test
  logic [2:0]  obs_flags;
  logic [31:0] obs_data;

  always_comb begin
    obs_flags = {bus2.empty, bus2.full, bus2.almost_full};
    obs_data  = bus2.data_read;
    if (sel != 0) begin
      obs_flags = {bus3.empty, bus3.full, bus3.almost_full};
      obs_data  = bus3.data_read;
    end
  end

  function automatic logic [2:0] model_flags();
    return {mq.size() == 0, mq.size() == mcap, mq.size() == mcap - 1};
  endfunction

  task automatic set_idle();
    bus2.write = 1'b0; bus2.next_read = 1'b0; bus2.data_write = '0; rst2 = 1'b1;
    bus3.write = 1'b0; bus3.next_read = 1'b0; bus3.data_write = '0; rst3 = 1'b1;
  endtask

  // One clock of stimulus on the selected instance; the model advances with it.
  task automatic cycle(input logic w, input logic [31:0] d, input logic r, input logic rs);
    logic        was_full;
    logic        was_empty;
    logic [31:0] dummy;
    if (sel == 0) begin
      bus2.write = w; bus2.data_write = d; bus2.next_read = r; rst2 = rs;
    end else begin
      bus3.write = w; bus3.data_write = d; bus3.next_read = r; rst3 = rs;
    end
    @(posedge clk);
    if (!rs) begin
      mq.delete();
    end else begin
      was_full  = (mq.size() == mcap);
      was_empty = (mq.size() == 0);
      if (r && !was_empty) dummy = mq.pop_front();
      if (w && !was_full) mq.push_back(d);
    end
    #1;
    set_idle();
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel  = s;
      mcap = (s == 0) ? 2 : 3;
      cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      n_cmp++;
      if (obs_flags !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_flags inst=%0d got=%b want=100", s, obs_flags);
      end
      n_cmp++;
      if (obs_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_data inst=%0d got=%h want=0", s, obs_data);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic        tw [6] = '{1, 1, 1, 0, 0, 0};
    logic        tr [6] = '{0, 0, 0, 1, 1, 1};
    logic [31:0] td [6] = '{32'hA1, 32'hB2, 32'hC3, 0, 0, 0};
    logic [2:0]  ef [6] = '{3'b001, 3'b010, 3'b010, 3'b001, 3'b100, 3'b100};
    logic [31:0] ed [6] = '{32'hA1, 32'hA1, 32'hA1, 32'hB2, 0, 0};
    sel = 0; mcap = 2;
    cycle(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(tw[i], td[i], tr[i], 1'b1);
      n_cmp++;
      if (obs_flags !== ef[i]) begin
        n_fail++;
        $display("FAIL fill_drain_flags step=%0d got=%b want=%b", i, obs_flags, ef[i]);
      end
      if (!ef[i][2]) begin
        n_cmp++;
        if (obs_data !== ed[i]) begin
          n_fail++;
          $display("FAIL fill_drain_data step=%0d got=%h want=%h", i, obs_data, ed[i]);
        end
      end
    end
  endtask

  task automatic test_full_rw();
    sel = 0; mcap = 2;
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA1, 1'b0, 1'b1);
    cycle(1'b1, 32'hB2, 1'b0, 1'b1);
    cycle(1'b1, 32'hD4, 1'b1, 1'b1);
    n_cmp++;
    if (obs_flags !== 3'b001 || obs_data !== 32'hB2) begin
      n_fail++;
      $display("FAIL full_rw got=%b/%h want=001/000000b2", obs_flags, obs_data);
    end
    cycle(1'b0, 0, 1'b1, 1'b1);
    n_cmp++;
    if (obs_flags !== 3'b100) begin
      n_fail++;
      $display("FAIL full_rw_dropped got=%b want=100", obs_flags);
    end
  endtask

  task automatic test_empty_rw();
    sel = 0; mcap = 2;
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 1'b1, 1'b1);
    n_cmp++;
    if (obs_flags !== 3'b001 || obs_data !== 32'h55) begin
      n_fail++;
      $display("FAIL empty_rw got=%b/%h want=001/00000055", obs_flags, obs_data);
    end
  endtask

  task automatic test_stream3();
    logic [31:0] got [$];
    logic        w;
    logic        r;
    sel = 1; mcap = 3;
    cycle(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      w = (i < 10);
      r = (i >= 2);
      if (r && !obs_flags[2]) got.push_back(obs_data);
      cycle(w, 32'(i), r, 1'b1);
      n_cmp++;
      if (obs_flags !== model_flags()) begin
        n_fail++;
        $display("FAIL stream3_flags step=%0d got=%b want=%b", i, obs_flags, model_flags());
      end
    end
    n_cmp++;
    if (got.size() != 10) begin
      n_fail++;
      $display("FAIL stream3_count got=%0d want=10", got.size());
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_cmp++;
      if (got[i] !== 32'(i)) begin
        n_fail++;
        $display("FAIL stream3_order idx=%0d got=%h want=%h", i, got[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 0; mcap = 2;
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 32'h11, 1'b0, 1'b1);
    cycle(1'b1, 32'h22, 1'b0, 1'b1);
    cycle(1'b1, 32'h33, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs_flags !== 3'b100 || obs_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_mid step=%0d got=%b/%h want=100/00000000", i, obs_flags, obs_data);
      end
      cycle(1'b0, 0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_random();
    logic        w;
    logic        r;
    logic        rs;
    logic [31:0] d;
    for (int s = 0; s < 2; s++) begin
      sel  = s;
      mcap = (s == 0) ? 2 : 3;
      cycle(1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 400; i++) begin
        w  = 1'($urandom_range(0, 1));
        r  = 1'($urandom_range(0, 1));
        rs = ($urandom_range(0, 39) != 0);
        d  = $urandom;
        cycle(w, d, r, rs);
        n_cmp++;
        if (obs_flags !== model_flags()) begin
          n_fail++;
          $display("FAIL random_flags inst=%0d step=%0d got=%b want=%b", s, i, obs_flags, model_flags());
        end
        if (mq.size() != 0) begin
          n_cmp++;
          if (obs_data !== mq[0]) begin
            n_fail++;
            $display("FAIL random_data inst=%0d step=%0d got=%h want=%h", s, i, obs_data, mq[0]);
          end
        end
      end
    end
  endtask

  initial begin
    set_idle();
    rst2 = 1'b0;
    rst3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    set_idle();
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_stream3();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock FIFO with first-word-fall-through read port, used as the input buffer of compute blocks (e.g. the multiplier stage) to decouple producer and consumer handshakes. Stores up to NUM_SLOTS words of DATA_WIDTH bits. Reports empty, full and almost_full status. The head word is always visible on data_read.

## Interface
- NUM_SLOTS, default 4: storage depth in words; must be at least 2.
- LOG_NUM_SLOTS, default 2: pointer width, equal to ceil(log2(NUM_SLOTS)).
- DATA_WIDTH, default 32: word width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- data_write  in  DATA_WIDTH  word to enqueue.
- write  in  1  enqueue request, sampled on the rising edge.
- full  out  1  occupancy equals NUM_SLOTS.
- almost_full  out  1  occupancy equals NUM_SLOTS-1.
- data_read  out  DATA_WIDTH  head word (first-word fall-through).
- next_read  in  1  dequeue request; consumes the word currently on data_read.
- empty  out  1  occupancy equals 0.

## Operation
- State:
  - circular storage of NUM_SLOTS words;
  - write pointer and read pointer, each LOG_NUM_SLOTS bits;
  - occupancy count, LOG_NUM_SLOTS+1 bits.
- Pointers advance by 1 and wrap from NUM_SLOTS-1 to 0. NUM_SLOTS need not be a power of two.
- Write accepted = write & ~full. The word is stored at the write pointer, and the write pointer advances.
- Read accepted = next_read & ~empty. The read pointer advances.
- Count update per cycle:
  - +1 on an accepted write only;
  - -1 on an accepted read only;
  - unchanged when both are accepted or neither is.
- Write while full is silently dropped: no state change, no error flag.
- Read while empty is ignored.
- Simultaneous write and next_read:
  - Both requests are judged on the flags at the start of the cycle.
  - When full: the read is accepted and the write is dropped.
  - When empty: the write is accepted and the read is ignored. There is no same-cycle bypass.
  - Otherwise: both are accepted and the count is unchanged.
- data_read = storage[read pointer], combinational from the registered state.
  - Its value is meaningful only while empty=0.
  - When empty=1 it holds stale data and must not be consumed.
- Flags are combinational decodes of the registered count, so they are glitch-free relative to clk:
  - empty = (count==0);
  - full = (count==NUM_SLOTS);
  - almost_full = (count==NUM_SLOTS-1).
- Ordering: words are dequeued in exactly the order they were accepted. No loss or duplication except dropped writes while full.

## Timing
- Reset (rst=0 at a rising edge):
  - count, both pointers and all storage words are cleared to 0;
  - empty=1, full=0, almost_full=0, data_read=0.
- Reset takes priority over write and next_read in the same cycle.
- Reset mid-operation discards all contents.
- Write-to-read latency is 1 cycle. A word written at edge N appears on data_read, with empty=0, after edge N if the FIFO was empty.
- Dequeue takes effect at the edge where next_read=1. The next word, or empty=1, is presented after that edge.
- A consumer may hold next_read=1 continuously to drain one word per cycle.
- A producer that gates write with ~full & ~almost_full never overflows, because the flags lag by at most one accepted write.
- Sustained throughput is one write and one read per cycle when 0 < count < NUM_SLOTS.

## Test plan
1. Reset, NUM_SLOTS=2, DATA_WIDTH=32 -> empty=1, full=0, almost_full=0, data_read=0.
2. Write 0xA1, then 0xB2, on consecutive cycles.
   - After the 1st edge: empty=0, almost_full=1, data_read=0xA1.
   - After the 2nd edge: full=1, almost_full=0.
   - A 3rd write of 0xC3 while full is dropped.
   - Then drain with next_read held high: data_read shows 0xA1 then 0xB2, after which empty=1.
3. Full FIFO, write of 0xD4 and next_read in the same cycle -> 0xA1 is consumed, 0xD4 is dropped, count becomes 1, data_read=0xB2.
4. Empty FIFO, write of 0x55 and next_read in the same cycle -> the read is ignored, count becomes 1, data_read=0x55 on the next cycle.
5. NUM_SLOTS=3 (non-power-of-two), stream 0x00..0x09 with write and next_read concurrent at half occupancy -> output sequence is 0x00..0x09 in order, with correct pointer wrap and no flag glitches.
6. Reset asserted with 2 words stored while write=1 -> empty=1, count 0, the incoming word is not stored.
